uv_sram_ctrl: RTL and testbench
===============================

UV_SRAM_CTRL -- requirements
Module: uv_sram_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, SRAM address width.
REQ-002 SHALL have parameter RAM_DW, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter RAM_MW, default RAM_DW/8, byte-mask width.
REQ-004 SHALL have parameter RAM_DLY, default 0, extra SRAM access cycles (matches the SRAM model's RAM_DLY).
REQ-005 SHALL have parameter RSP_DEPTH, default 4, response FIFO depth (power of 2, >=2).
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset. One clock; reset is synchronous and active-low.
REQ-007 SHALL have ports: req_vld in 1 request valid; req_rdy out 1 request ready; req_read in 1 1=read, 0=write; req_addr in RAM_AW address; req_data in RAM_DW write data; req_mask in RAM_MW byte enables.
REQ-008 SHALL have ports: rsp_vld out 1 response valid; rsp_rdy in 1 response ready; rsp_data out RAM_DW read data (zero for write responses).
REQ-009 SHALL have SRAM-side ports: ram_ce out 1; ram_we out 1; ram_a out RAM_AW; ram_d out RAM_DW; ram_m out RAM_MW; ram_q in RAM_DW (registered SRAM read data).

Function
REQ-010 SHALL accept a request on a cycle with req_vld & req_rdy and issue it to the SRAM in that same cycle: ram_ce=1, ram_we=~req_read, ram_a/ram_d/ram_m = req_addr/req_data/req_mask (combinational pass-through).
REQ-011 SHALL hold ram_ce=0 on every cycle without an accepted request.
REQ-012 SHALL implement FSM IDLE/WAIT: IDLE->WAIT on acceptance when RAM_DLY>0, loading a wait counter with RAM_DLY; WAIT decrements each cycle and returns to IDLE at count 0; with RAM_DLY=0 the FSM stays in IDLE (one access per cycle).
REQ-013 SHALL drive req_rdy=1 only in IDLE and when credits (in-flight responses plus FIFO occupancy) < RSP_DEPTH; req_rdy SHALL not depend on req_vld or payload.
REQ-014 SHALL capture ram_q into the response FIFO exactly RAM_DLY+1 cycles after an accepted read's issue edge, tracked by a RAM_DLY+1-stage valid shift register.
REQ-015 SHALL present FIFO head on rsp_vld/rsp_data; a beat pops on rsp_vld & rsp_rdy; rsp_data SHALL be stable while rsp_vld & ~rsp_rdy.
REQ-016 SHALL return responses in request order.
REQ-017 SHALL keep the credit count unchanged when an issue and a pop occur in the same cycle; SHALL never overflow the FIFO.
REQ-018 SHALL allow push and pop in the same cycle when FIFO full (pop frees slot, push fills it); FIFO pointers wrap modulo RSP_DEPTH.

Reset
REQ-019 While rst_n=0 at a clk edge: FSM->IDLE, wait counter, valid shift register, FIFO pointers and credit count ->0, rsp_data->0.
REQ-020 SHALL force req_rdy=0 and ram_ce=0 combinationally while rst_n=0; rsp_vld=0 from the first edge with rst_n=0.
REQ-021 Reset mid-operation SHALL discard in-flight reads and queued responses; none SHALL appear after reset release.

Configuration
REQ-022 Macro UV_SRAM_CTRL_WR_RSP_EN: when defined, each accepted write consumes a credit and enqueues one response (rsp_data=0) at the same latency as a read; when undefined, writes consume no credit and produce no response, and req_rdy ignores credits only for... no: credit check unchanged, writes simply never enqueue.

Verification
REQ-023 RAM_DLY=0: write addr 0x10 data 0xDEADBEEF mask 0xF, then read 0x10 next cycle, rsp_rdy=1 -> rsp_vld one cycle after read issue with rsp_data=0xDEADBEEF.
REQ-024 RAM_DLY=2: two back-to-back read requests -> req_rdy low for 2 cycles after first accept; each rsp arrives 3 cycles after its issue, in order.
REQ-025 Partial write: preload 0x11223344 at 0x05, write 0xAABBCCDD mask 0x5, read -> 0x11BB33DD.
REQ-026 Backpressure: rsp_rdy=0, RSP_DEPTH=4, issue 6 reads -> exactly 4 accepted, req_rdy=0 thereafter; raise rsp_rdy -> 4 in-order beats, then remaining 2 accepted.
REQ-027 Reset with 2 reads in flight (RAM_DLY=2) -> rsp_vld stays 0 after release, credits 0, req_rdy=1 one cycle after release.
REQ-028 Macro defined vs undefined: single write -> one response beat with rsp_data=0 vs no response beat.

Source files
------------

// File: rtl/uv_sram_ctrl.sv
// Request/response front end for a synchronous SRAM with RAM_DLY extra access cycles.
// Define UV_SRAM_CTRL_WR_RSP_EN to have accepted writes return a zero-data response beat.
module uv_sram_ctrl #(
    parameter int RAM_AW    = 8,
    parameter int RAM_DW    = 32,
    parameter int RAM_MW    = RAM_DW / 8,
    parameter int RAM_DLY   = 0,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_read,
    input  logic [RAM_AW-1:0] req_addr,
    input  logic [RAM_DW-1:0] req_data,
    input  logic [RAM_MW-1:0] req_mask,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [RAM_DW-1:0] rsp_data,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [RAM_DW-1:0] ram_d,
    output logic [RAM_MW-1:0] ram_m,
    input  logic [RAM_DW-1:0] ram_q
);

    // state  | meaning
    // S_IDLE | may accept a request this cycle
    // S_WAIT | SRAM busy for RAM_DLY more cycles after an accept
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CRW = PW + 1;
    localparam int CW  = (RAM_DLY > 0) ? $clog2(RAM_DLY + 1) : 1;
    localparam int SRW = RAM_DLY + 1;

`ifdef UV_SRAM_CTRL_WR_RSP_EN
    localparam bit WR_RSP = 1'b1;
`else
    localparam bit WR_RSP = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [SRW-1:0]    sr_vld_q, sr_vld_d;
    logic [SRW-1:0]    sr_rd_q, sr_rd_d;
    logic [CRW-1:0]    credit_q, credit_d;
    logic [CRW-1:0]    occ_q, occ_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [RAM_DW-1:0] fifo_q [RSP_DEPTH];

    logic              accept;
    logic              consume;
    logic              push;
    logic              pop;
    logic [RAM_DW-1:0] push_data;

    assign req_rdy = rst_n & (state_q == S_IDLE) & (credit_q < CRW'(RSP_DEPTH));
    assign accept  = req_vld & req_rdy;
    assign consume = accept & (req_read | WR_RSP);

    assign ram_ce = accept;
    assign ram_we = ~req_read;
    assign ram_a  = req_addr;
    assign ram_d  = req_data;
    assign ram_m  = req_mask;

    // Stage SRW-1 lines up with the edge where the SRAM's registered q is valid.
    assign sr_vld_d  = SRW'({sr_vld_q, consume});
    assign sr_rd_d   = SRW'({sr_rd_q, accept & req_read});
    assign push      = sr_vld_q[SRW-1];
    assign push_data = sr_rd_q[SRW-1] ? ram_q : '0;

    assign rsp_vld  = (occ_q != '0);
    assign pop      = rsp_vld & rsp_rdy;
    assign rsp_data = rsp_vld ? fifo_q[rd_ptr_q] : '0;

    assign credit_d = credit_q + CRW'(consume) - CRW'(pop);
    assign occ_d    = occ_q + CRW'(push) - CRW'(pop);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (RAM_DLY > 0)) begin
                    state_d = S_WAIT;
                    wcnt_d  = CW'(RAM_DLY);
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - CW'(1);
                if (wcnt_q <= CW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            sr_vld_q <= '0;
            sr_rd_q  <= '0;
            credit_q <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            sr_vld_q <= sr_vld_d;
            sr_rd_q  <= sr_rd_d;
            credit_q <= credit_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
        end
    end

    // Storage needs no reset: rsp_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_uv_sram_ctrl.sv
// Directed bench for uv_sram_ctrl: one instance with RAM_DLY=0, one with RAM_DLY=2,
// each backed by a simple behavioural SRAM with matching latency.
module tb_uv_sram_ctrl;

`ifdef UV_SRAM_CTRL_WR_RSP_EN
    localparam bit WR_RSP = 1'b1;
`else
    localparam bit WR_RSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_read, rsp_rdy;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic        sel;

    logic        rdy0, rvld0, ce0, we0;
    logic [7:0]  a0;
    logic [31:0] d0, rdat0, q0;
    logic [3:0]  m0;
    logic        rdy2, rvld2, ce2, we2;
    logic [7:0]  a2;
    logic [31:0] d2, rdat2, q2, p2a, p2b;
    logic [3:0]  m2;

    logic [31:0] mem0 [256];
    logic [31:0] mem2 [256];

    logic        rdy, rvld;
    logic [31:0] rdata;
    assign rdy   = sel ? rdy2 : rdy0;
    assign rvld  = sel ? rvld2 : rvld0;
    assign rdata = sel ? rdat2 : rdat0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uv_sram_ctrl #(.RAM_DLY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(rdy0), .req_read(req_read),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rsp_vld(rvld0), .rsp_rdy(rsp_rdy), .rsp_data(rdat0),
        .ram_ce(ce0), .ram_we(we0), .ram_a(a0), .ram_d(d0), .ram_m(m0), .ram_q(q0)
    );

    uv_sram_ctrl #(.RAM_DLY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(rdy2), .req_read(req_read),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rsp_vld(rvld2), .rsp_rdy(rsp_rdy), .rsp_data(rdat2),
        .ram_ce(ce2), .ram_we(we2), .ram_a(a2), .ram_d(d2), .ram_m(m2), .ram_q(q2)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (ce0) begin
            if (we0) mem0[a0] <= merge(mem0[a0], d0, m0);
            else     q0 <= mem0[a0];
        end
    end

    always @(posedge clk) begin
        if (ce2 && we2) mem2[a2] <= merge(mem2[a2], d2, m2);
        if (ce2 && !we2) p2a <= mem2[a2];
        p2b <= p2a;
        q2  <= p2b;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic do_req(bit rd, logic [7:0] a, logic [31:0] d, logic [3:0] m);
        int n;
        n = 0;
        req_read = rd; req_addr = a; req_data = d; req_mask = m; req_vld = 1'b1;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic expect_rsp(string tag, logic [31:0] exp);
        int n;
        n = 0;
        while (!rvld && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvld) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk(tag, rdata, exp);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d, logic [3:0] m);
        do_req(1'b0, a, d, m);
`ifdef UV_SRAM_CTRL_WR_RSP_EN
        expect_rsp("wr_rsp", 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   acc;
        logic r;
        logic seen;

        rst_n = 1'b0; sel = 1'b0; rsp_rdy = 1'b1;
        req_vld = 1'b1; req_read = 1'b1; req_addr = 8'h00; req_data = '0; req_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_rdy2", rdy2, 1'b0);
        chk("rst_ce0", ce0, 1'b0);
        chk("rst_rvld0", rvld0, 1'b0);
        chk("rst_rdata0", rdat0, 32'd0);
        rst_n = 1'b1; req_vld = 1'b0;
        #1 chk("rst_rel_rdy0", rdy0, 1'b1);

        // Write then read back-to-back at RAM_DLY=0
        @(negedge clk);
        req_vld = 1'b1; req_read = 1'b0; req_addr = 8'h10; req_data = 32'hDEADBEEF; req_mask = 4'hF;
        #1;
        chk("t1_ce", ce0, 1'b1);
        chk("t1_we", we0, 1'b1);
        chk("t1_addr", a0, 8'h10);
        chk("t1_wdata", d0, 32'hDEADBEEF);
        @(negedge clk);
        req_read = 1'b1;
        #1 chk("t1_rd_we", we0, 1'b0);
        @(negedge clk);
        req_vld = 1'b0;
        chk("t1_wr_rsp_vld", rvld0, WR_RSP);
        chk("t1_wr_rsp_data", rdat0, 32'd0);
        @(negedge clk);
        chk("t1_rd_rsp_vld", rvld0, 1'b1);
        chk("t1_rd_rsp_data", rdat0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_idle_vld", rvld0, 1'b0);
        chk("t1_idle_ce", ce0, 1'b0);

        // Partial writes
        wr(8'h05, 32'h11223344, 4'hF);
        wr(8'h05, 32'hAABBCCDD, 4'h5);
        do_req(1'b1, 8'h05, 32'd0, 4'h0);
        expect_rsp("t2_mask5", 32'h11BB33DD);
        wr(8'h06, 32'h01020304, 4'hF);
        wr(8'h06, 32'hF0E0D0C0, 4'hA);
        do_req(1'b1, 8'h06, 32'd0, 4'h0);
        expect_rsp("t2_maskA", 32'hF002D004);

        // Write response presence depends on build option
        rsp_rdy = 1'b0;
        do_req(1'b0, 8'h40, 32'h12345678, 4'hF);
        repeat (3) @(negedge clk);
        chk("t6_wr_rsp_vld", rvld0, WR_RSP);
        chk("t6_wr_rsp_data", rdat0, 32'd0);
        rsp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_drained", rvld0, 1'b0);
        do_req(1'b1, 8'h40, 32'd0, 4'h0);
        expect_rsp("t6_readback", 32'h12345678);

        // Backpressure with RSP_DEPTH=4
        for (int i = 0; i < 6; i++) wr(8'(8'h30 + i), 32'hA5000000 + i, 4'hF);
        rsp_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_read = 1'b1;
            req_addr = 8'(8'h30 + acc);
            req_vld  = (acc < 6);
            r = rdy;
            @(posedge clk);
            if (r && req_vld) acc++;
            @(negedge clk);
        end
        req_vld = 1'b0;
        chk("t4_accepted", acc, 4);
        chk("t4_rdy_full", rdy0, 1'b0);
        chk("t4_head_vld", rvld0, 1'b1);
        chk("t4_head_data", rdat0, 32'hA5000000);
        repeat (2) @(negedge clk);
        chk("t4_head_hold", rdat0, 32'hA5000000);
        rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) expect_rsp("t4_drain", 32'hA5000000 + i);
        do_req(1'b1, 8'h34, 32'd0, 4'h0);
        expect_rsp("t4_rest4", 32'hA5000004);
        do_req(1'b1, 8'h35, 32'd0, 4'h0);
        expect_rsp("t4_rest5", 32'hA5000005);

        // RAM_DLY=2 back-to-back reads
        sel = 1'b1;
        wr(8'h20, 32'hCAFE0001, 4'hF);
        wr(8'h21, 32'hCAFE0002, 4'hF);
        repeat (4) @(negedge clk);
        chk("t3_start_rdy", rdy2, 1'b1);
        req_vld = 1'b1; req_read = 1'b1; req_addr = 8'h20;
        @(negedge clk);
        req_addr = 8'h21;
        chk("t3_wait1_rdy", rdy2, 1'b0);
        chk("t3_wait1_ce", ce2, 1'b0);
        @(negedge clk);
        chk("t3_wait2_rdy", rdy2, 1'b0);
        @(negedge clk);
        chk("t3_back_rdy", rdy2, 1'b1);
        chk("t3_rsp1_early", rvld2, 1'b0);
        @(negedge clk);
        req_vld = 1'b0;
        chk("t3_rsp1_vld", rvld2, 1'b1);
        chk("t3_rsp1_data", rdat2, 32'hCAFE0001);
        repeat (2) @(negedge clk);
        chk("t3_rsp2_early", rvld2, 1'b0);
        @(negedge clk);
        chk("t3_rsp2_vld", rvld2, 1'b1);
        chk("t3_rsp2_data", rdat2, 32'hCAFE0002);
        repeat (2) @(negedge clk);

        // Reset with reads in flight at RAM_DLY=2
        rsp_rdy = 1'b0;
        do_req(1'b1, 8'h20, 32'd0, 4'h0);
        do_req(1'b1, 8'h21, 32'd0, 4'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_rdy", rdy2, 1'b0);
        chk("t5_rst_vld", rvld2, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rel_rdy", rdy2, 1'b1);
        rsp_rdy = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rvld2) seen = 1'b1;
        end
        chk("t5_no_stale_rsp", seen, 1'b0);
        rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_req(1'b1, 8'(8'h20 + (i % 2)), 32'd0, 4'h0);
        rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) expect_rsp("t5_full_credit", (i % 2 == 0) ? 32'hCAFE0001 : 32'hCAFE0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
